// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm ringer slice.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } state_t;

   localparam int DEF_BEEP_ON      = 2;
   localparam int DEF_BEEP_OFF     = 2;
   localparam int DEF_SNOOZE_TICKS = 4;
   localparam int DEF_RING_TIMEOUT = 8;
   localparam int DEF_MAX_SNOOZE   = 2;
   localparam int DEF_ESC_TICKS    = 2;

   localparam logic [1:0] LEVEL_MAX = 2'd3;

endpackage

// File: rtl/alarm_ringer_if.sv
// User-facing alarm signals: control inputs from the clock stage and
// buttons, plus the buzzer and status outputs.
interface alarm_ringer_if;
   logic       arm;
   logic       alarm;
   logic       sec_tick;
   logic       snooze_btn;
   logic       dismiss_btn;
   logic       buzzer;
   logic [1:0] level;
   logic       ringing;
   logic       snoozing;
   logic [2:0] snooze_count;

   // Driver side (clock stage, buttons) observes the status outputs.
   modport master (
      output arm, alarm, sec_tick, snooze_btn, dismiss_btn,
      input  buzzer, level, ringing, snoozing, snooze_count
   );

   // Ringer side.
   modport slave (
      input  arm, alarm, sec_tick, snooze_btn, dismiss_btn,
      output buzzer, level, ringing, snoozing, snooze_count
   );
endinterface

// File: rtl/alarm_ringer_beep_gen.sv
// Beep pattern generator: BEEP_ON cycles high then BEEP_OFF cycles low,
// repeating while enabled. restart forces the pattern back to the first
// ON cycle; the output is registered.
module beep_gen #(
   parameter int BEEP_ON  = 2,
   parameter int BEEP_OFF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic beep
);

   localparam int PERIOD = BEEP_ON + BEEP_OFF;
   localparam int PH_W   = $clog2(PERIOD + 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
   localparam logic [PH_W-1:0] PH_ON   = PH_W'(BEEP_ON);

   logic [PH_W-1:0] phase_reg;
   logic [PH_W-1:0] phase_next;
   logic            beep_reg;

   // Position within the beep period for the following cycle.
   always_comb begin
      phase_next = (phase_reg == PH_LAST) ? '0 : phase_reg + PH_W'(1);
   end

   // Phase counter runs every clk while enabled; output decoded one cycle early.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_reg <= '0;
         beep_reg  <= 1'b0;
      end else if (restart) begin
         phase_reg <= '0;
         beep_reg  <= 1'b1;
      end else if (enable) begin
         phase_reg <= phase_next;
         beep_reg  <= (phase_next < PH_ON);
      end else begin
         phase_reg <= '0;
         beep_reg  <= 1'b0;
      end
   end

   assign beep = beep_reg;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: turns the level alarm match flag into a ringing sequence
// with pulsed buzzer, bounded snooze, dismiss and automatic ring timeout.
// Optional volume escalation is enabled by defining ESCALATE_EN; without
// it level is tied to LEVEL_MAX and no escalation counter exists.
module alarm_ringer
   import alarm_pkg::*;
#(
   parameter int BEEP_ON      = DEF_BEEP_ON,
   parameter int BEEP_OFF     = DEF_BEEP_OFF,
   parameter int SNOOZE_TICKS = DEF_SNOOZE_TICKS,
   parameter int RING_TIMEOUT = DEF_RING_TIMEOUT,
`ifdef ESCALATE_EN
   parameter int ESC_TICKS    = DEF_ESC_TICKS,
`endif
   parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE
) (
   input logic           clk,
   input logic           reset,
   alarm_ringer_if.slave bus
);

   localparam int RT_W = $clog2(RING_TIMEOUT + 1);
   localparam int ST_W = $clog2(SNOOZE_TICKS + 1);
   localparam logic [RT_W-1:0] RT_LAST = RT_W'(RING_TIMEOUT - 1);
   localparam logic [RT_W-1:0] RT_MAX  = RT_W'(RING_TIMEOUT);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(SNOOZE_TICKS - 1);
   localparam logic [ST_W-1:0] ST_MAX  = ST_W'(SNOOZE_TICKS);
   localparam logic [2:0]      SNZ_MAX = 3'(MAX_SNOOZE);

   state_t          state_reg;
   state_t          state_next;
   logic            alarm_q_reg;
   logic            trig;
   logic [RT_W-1:0] ring_timer_reg;
   logic [ST_W-1:0] snz_timer_reg;
   logic [2:0]      snooze_count_reg;
   logic            ringing_reg;
   logic            snoozing_reg;
   logic            beep_enable;
   logic            beep_restart;
   logic            buzzer_w;

   // Next-state decision; priority is arm, then dismiss, then snooze, then timers.
   always_comb begin
      trig       = bus.alarm & ~alarm_q_reg;
      state_next = state_reg;
      if (!bus.arm) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (trig) state_next = RINGING;
            end
            RINGING: begin
               if (bus.dismiss_btn)
                  state_next = IDLE;
               else if (bus.snooze_btn && (snooze_count_reg < SNZ_MAX))
                  state_next = SNOOZE;
               else if (bus.sec_tick && (ring_timer_reg == RT_LAST))
                  state_next = IDLE;
            end
            SNOOZE: begin
               if (bus.dismiss_btn)
                  state_next = IDLE;
               else if (bus.sec_tick && (snz_timer_reg == ST_LAST))
                  state_next = RINGING;
            end
            default: state_next = IDLE;
         endcase
      end
      beep_enable  = (state_next == RINGING);
      beep_restart = beep_enable && (state_reg != RINGING);
   end

   // State, timers, snooze count and Moore status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         alarm_q_reg      <= 1'b0;
         ring_timer_reg   <= '0;
         snz_timer_reg    <= '0;
         snooze_count_reg <= '0;
         ringing_reg      <= 1'b0;
         snoozing_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         alarm_q_reg  <= bus.alarm;
         ringing_reg  <= (state_next == RINGING);
         snoozing_reg <= (state_next == SNOOZE);

         // Timers restart on every state change and saturate otherwise.
         if (state_next != state_reg) begin
            ring_timer_reg <= '0;
            snz_timer_reg  <= '0;
         end else begin
            if (state_reg == RINGING && bus.sec_tick && ring_timer_reg != RT_MAX)
               ring_timer_reg <= ring_timer_reg + RT_W'(1);
            if (state_reg == SNOOZE && bus.sec_tick && snz_timer_reg != ST_MAX)
               snz_timer_reg <= snz_timer_reg + ST_W'(1);
         end

         // Count is per alarm event: any return to IDLE clears it.
         if (state_next == IDLE)
            snooze_count_reg <= '0;
         else if (state_reg == RINGING && state_next == SNOOZE)
            snooze_count_reg <= snooze_count_reg + 3'd1;
      end
   end

   beep_gen #(
      .BEEP_ON  (BEEP_ON),
      .BEEP_OFF (BEEP_OFF)
   ) u_beep (
      .clk     (clk),
      .reset   (reset),
      .enable  (beep_enable),
      .restart (beep_restart),
      .beep    (buzzer_w)
   );

`ifdef ESCALATE_EN
   localparam int EC_W = $clog2(ESC_TICKS + 1);
   localparam logic [EC_W-1:0] EC_LAST = EC_W'(ESC_TICKS - 1);

   logic [EC_W-1:0] esc_timer_reg;
   logic [1:0]      level_reg;

   // Volume steps up every ESC_TICKS seconds of continuous ringing.
   always_ff @(posedge clk) begin
      if (reset) begin
         esc_timer_reg <= '0;
         level_reg     <= 2'd0;
      end else if (state_reg == RINGING && state_next == RINGING) begin
         if (bus.sec_tick) begin
            if (esc_timer_reg == EC_LAST) begin
               esc_timer_reg <= '0;
               if (level_reg != LEVEL_MAX) level_reg <= level_reg + 2'd1;
            end else begin
               esc_timer_reg <= esc_timer_reg + EC_W'(1);
            end
         end
      end else begin
         esc_timer_reg <= '0;
         level_reg     <= 2'd0;
      end
   end

   assign bus.level = level_reg;
`else
   assign bus.level = LEVEL_MAX;
`endif

   assign bus.buzzer       = buzzer_w;
   assign bus.ringing      = ringing_reg;
   assign bus.snoozing     = snoozing_reg;
   assign bus.snooze_count = snooze_count_reg;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with hand-computed expectations.
// Level checks follow ESCALATE_EN when the macro is defined for the build.
module tb_alarm_ringer;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

`ifdef ESCALATE_EN
   localparam int RST_LEVEL = 0;
`else
   localparam int RST_LEVEL = 3;
`endif

   alarm_ringer_if bus ();

   alarm_ringer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Single comparison point: one line per check.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      bus.sec_tick = 1'b1;
      step();
      bus.sec_tick = 1'b0;
   endtask

   task automatic press_snooze();
      bus.snooze_btn = 1'b1;
      step();
      bus.snooze_btn = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      bus.arm         = 1'b1;
      bus.alarm       = 1'b0;
      bus.sec_tick    = 1'b0;
      bus.snooze_btn  = 1'b0;
      bus.dismiss_btn = 1'b0;
      step();
      step();
      chk("rst_buzzer", bus.buzzer, 0);
      chk("rst_ringing", bus.ringing, 0);
      chk("rst_snoozing", bus.snoozing, 0);
      chk("rst_count", bus.snooze_count, 0);
      chk("rst_level", bus.level, RST_LEVEL);
      reset = 1'b0;
      step();

      // 1: held alarm triggers once; beep pattern 1,1,0,0; timeout after 8 ticks
      bus.alarm = 1'b1;
      step();
      chk("t1_ringing", bus.ringing, 1);
      chk("t1_level0", bus.level, RST_LEVEL);
      for (int k = 0; k < 16; k++) begin
         if (k > 0) step();
         chk($sformatf("t1_buzz%0d", k), bus.buzzer, ((k % 4) < 2) ? 1 : 0);
      end
      for (int n = 1; n <= 7; n++) begin
         tick();
         chk($sformatf("t1_ring_tick%0d", n), bus.ringing, 1);
`ifdef ESCALATE_EN
         chk($sformatf("t1_level_tick%0d", n), bus.level, (n / 2 > 3) ? 3 : n / 2);
`endif
      end
      tick();
      chk("t1_timeout_ringing", bus.ringing, 0);
      chk("t1_timeout_buzzer", bus.buzzer, 0);
      chk("t1_timeout_level", bus.level, RST_LEVEL);
      step();
      step();
      chk("t1_no_retrig", bus.ringing, 0);

      // 2: snooze, then re-ring after 4 ticks with fresh beep phase
      bus.alarm = 1'b0;
      step();
      bus.alarm = 1'b1;
      step();
      chk("t2_ringing", bus.ringing, 1);
      step();
      step();
      press_snooze();
      chk("t2_snoozing", bus.snoozing, 1);
      chk("t2_count", bus.snooze_count, 1);
      chk("t2_buzzer", bus.buzzer, 0);
      chk("t2_ring_off", bus.ringing, 0);
      for (int n = 1; n <= 3; n++) begin
         tick();
         chk($sformatf("t2_snz_tick%0d", n), bus.snoozing, 1);
      end
      tick();
      chk("t2_rering", bus.ringing, 1);
      chk("t2_buzz0", bus.buzzer, 1);
      step();
      chk("t2_buzz1", bus.buzzer, 1);
      step();
      chk("t2_buzz2", bus.buzzer, 0);

      // 3: second snooze allowed, third ignored
      press_snooze();
      chk("t3_count2", bus.snooze_count, 2);
      chk("t3_snoozing", bus.snoozing, 1);
      for (int n = 1; n <= 4; n++) tick();
      chk("t3_rering", bus.ringing, 1);
      press_snooze();
      chk("t3_ignored_ringing", bus.ringing, 1);
      chk("t3_ignored_snoozing", bus.snoozing, 0);
      chk("t3_ignored_count", bus.snooze_count, 2);

      // 4: dismiss beats snooze; held alarm does not retrigger
      bus.dismiss_btn = 1'b1;
      bus.snooze_btn  = 1'b1;
      step();
      bus.dismiss_btn = 1'b0;
      bus.snooze_btn  = 1'b0;
      chk("t4_ringing", bus.ringing, 0);
      chk("t4_snoozing", bus.snoozing, 0);
      chk("t4_count", bus.snooze_count, 0);
      chk("t4_level", bus.level, RST_LEVEL);
      step();
      step();
      chk("t4_held_no_retrig", bus.ringing, 0);
      bus.alarm = 1'b0;
      step();
      bus.alarm = 1'b1;
      step();
      chk("t4_retrig", bus.ringing, 1);

      // 5: disarm in SNOOZE, reset in RINGING, alarm high after reset retriggers
      press_snooze();
      chk("t5_snoozing", bus.snoozing, 1);
      bus.arm = 1'b0;
      step();
      chk("t5_disarm_snoozing", bus.snoozing, 0);
      chk("t5_disarm_ringing", bus.ringing, 0);
      chk("t5_disarm_count", bus.snooze_count, 0);
      bus.arm = 1'b1;
      step();
      chk("t5_rearm_no_trig", bus.ringing, 0);
      bus.alarm = 1'b0;
      step();
      bus.alarm = 1'b1;
      step();
      chk("t5_ring_again", bus.ringing, 1);
      reset = 1'b1;
      step();
      chk("t5_rst_ringing", bus.ringing, 0);
      chk("t5_rst_buzzer", bus.buzzer, 0);
      chk("t5_rst_count", bus.snooze_count, 0);
      chk("t5_rst_level", bus.level, RST_LEVEL);
      reset = 1'b0;
      step();
      chk("t5_post_rst_trig", bus.ringing, 1);
      chk("t5_post_rst_buzz", bus.buzzer, 1);
      bus.dismiss_btn = 1'b1;
      step();
      bus.dismiss_btn = 1'b0;
      chk("t5_dismiss", bus.ringing, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
